// File: rtl/sha256_msg_schedule.sv
// rtl/sha256_msg_schedule.sv - SHA-256 message schedule: loads 16 words, emits W[0..63]
// Sliding 16-word window; the oldest entry is always the word presented on w_out.
module sha256_msg_schedule (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_word,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] w_out,
  output logic [5:0]  round,
  output logic        last,
  output logic        busy
);

  typedef enum logic {LOAD, EMIT} state_t;

  state_t      state, state_nxt;
  logic [31:0] win [16];
  logic [3:0]  count;
  logic [5:0]  rnd;
  logic [31:0] new_word;
  logic        load_acc, emit_acc;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  assign new_word = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];
  assign load_acc = (state == LOAD) && in_valid;
  assign emit_acc = (state == EMIT) && out_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD: if (in_valid && count == 4'd15) state_nxt = EMIT;
      EMIT: if (out_ready && rnd == 6'd63) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) win[i] <= 32'd0;
    end else if (load_acc || emit_acc) begin
      for (int i = 0; i < 15; i++) win[i] <= win[i+1];
      win[15] <= load_acc ? in_word : new_word;
    end
  end

  // Both counters wrap naturally: count 15->0 on the 16th word, round 63->0 on the last consume.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 4'd0;
      rnd   <= 6'd0;
    end else begin
      if (load_acc) count <= count + 4'd1;
      if (emit_acc) rnd   <= rnd + 6'd1;
    end
  end

  assign in_ready  = (state == LOAD);
  assign out_valid = (state == EMIT);
  assign busy      = (state == EMIT);
  assign w_out     = win[0];
  assign round     = rnd;
  assign last      = (state == EMIT) && (rnd == 6'd63);

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// tb/tb_sha256_msg_schedule.sv - scoreboard bench for sha256_msg_schedule
module tb_sha256_msg_schedule;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_word;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] w_out;
  logic [5:0]  round;
  logic        last;
  logic        busy;

  sha256_msg_schedule dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_word(in_word), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .w_out(w_out), .round(round),
    .last(last), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w;
    logic [5:0]  r;
    logic        has_known;
    logic [31:0] known;
  } exp_t;

  exp_t        q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          or_mode = 0;
  logic [31:0] ws [64];
  logic [31:0] abc [16];
  logic [31:0] blk [16];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference: the textbook recurrence over a flat 64-entry array.
  task automatic push_block(input logic [31:0] b [16], input bit is_abc);
    exp_t e;
    for (int t = 0; t < 64; t++) begin
      if (t < 16) ws[t] = b[t];
      else ws[t] = (rotr(ws[t-2], 17) ^ rotr(ws[t-2], 19) ^ (ws[t-2] >> 10)) + ws[t-7]
                 + (rotr(ws[t-15], 7) ^ rotr(ws[t-15], 18) ^ (ws[t-15] >> 3)) + ws[t-16];
      e.w = ws[t];
      e.r = 6'(t);
      e.has_known = 1'b0;
      e.known = 32'd0;
      if (is_abc) begin
        case (t)
          0:  begin e.has_known = 1'b1; e.known = 32'h61626380; end
          15: begin e.has_known = 1'b1; e.known = 32'h00000018; end
          16: begin e.has_known = 1'b1; e.known = 32'h61626380; end
          17: begin e.has_known = 1'b1; e.known = 32'h000F0000; end
          63: begin e.has_known = 1'b1; e.known = 32'h12B1EDEB; end
          default: ;
        endcase
      end
      q.push_back(e);
    end
  endtask

  task automatic send_block(input logic [31:0] b [16], input bit is_abc, input bit gaps);
    int   budget;
    logic rdy;
    push_block(b, is_abc);
    for (int i = 0; i < 16; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      in_valid = 1'b1;
      in_word  = b[i];
      budget   = 0;
      do begin
        rdy = in_ready;
        @(posedge clk); #1;
        budget++;
      end while (!rdy && budget < 500);
      if (!rdy) chk("load_timeout", 64'(budget), 64'd0);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input bit rand_in);
    int budget = 0;
    while (busy && budget < 2000) begin
      if (rand_in) begin
        in_valid = 1'($urandom % 2);
        in_word  = $urandom;
      end
      @(posedge clk); #1;
      budget++;
    end
    in_valid = 1'b0;
    if (busy) chk("drain_timeout", 64'(budget), 64'd0);
  endtask

  task automatic rand_block();
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
  endtask

  // out_ready driver: 0 = always ready, 1 = random, 2 = toggle with a 5-cycle hold at round 20
  int   hold = 0;
  bit   held20 = 1'b0;
  always @(posedge clk) begin
    #1;
    case (or_mode)
      1: out_ready = 1'($urandom % 2);
      2: begin
        if (hold > 0) begin
          out_ready = 1'b0;
          hold--;
        end else if (out_valid && round == 6'd20 && !held20) begin
          held20    = 1'b1;
          hold      = 4;
          out_ready = 1'b0;
        end else begin
          out_ready = ~out_ready;
        end
      end
      default: out_ready = 1'b1;
    endcase
  end

  // Monitor: scoreboard pops, stall stability, output latency, return-to-load.
  bit          prev_ov = 1'b0;
  bit          stalled = 1'b0;
  bit          after_last = 1'b0;
  logic [31:0] saved_w;
  logic [5:0]  saved_r;
  int          acc = 0;
  int          exp_rise = -1;
  exp_t        e;

  always @(negedge clk) begin
    if (rst) begin
      prev_ov = 1'b0; stalled = 1'b0; after_last = 1'b0; acc = 0;
    end else begin
      if (after_last) begin
        chk("ready_after_last", 64'(in_ready), 64'd1);
        chk("valid_after_last", 64'(out_valid), 64'd0);
        after_last = 1'b0;
      end
      if (stalled) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_word", 64'(w_out), 64'(saved_w));
        chk("stall_round", 64'(round), 64'(saved_r));
        stalled = 1'b0;
      end
      if (out_valid && !prev_ov) chk("first_valid_cycle", 64'(cyc), 64'(exp_rise));
      if (in_valid && in_ready) begin
        acc++;
        if (acc == 16) begin
          exp_rise = cyc + 1;
          acc = 0;
        end
      end
      if (out_valid) begin
        if (out_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_output", 64'(round), 64'hFFFF);
          end else begin
            e = q.pop_front();
            chk("w_out", 64'(w_out), 64'(e.w));
            chk("round", 64'(round), 64'(e.r));
            chk("last", 64'(last), 64'(e.r == 6'd63));
            if (e.has_known) chk("abc_word", 64'(w_out), 64'(e.known));
          end
          if (last) after_last = 1'b1;
        end else begin
          stalled = 1'b1;
          saved_w = w_out;
          saved_r = round;
        end
      end
      prev_ov = out_valid;
    end
  end

  initial begin
    int budget;
    abc[0] = 32'h61626380;
    for (int i = 1; i < 15; i++) abc[i] = 32'd0;
    abc[15] = 32'h00000018;

    rst = 1'b1; in_valid = 1'b0; in_word = 32'd0; out_ready = 1'b1;
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_last", 64'(last), 64'd0);
    chk("rst_w_out", 64'(w_out), 64'd0);
    chk("rst_round", 64'(round), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    or_mode = 0; send_block(abc, 1'b1, 1'b0); drain(1'b0);
    or_mode = 2; held20 = 1'b0; send_block(abc, 1'b1, 1'b0); drain(1'b0);
    or_mode = 0; send_block(abc, 1'b1, 1'b1); drain(1'b0);

    or_mode = 1;
    rand_block(); send_block(blk, 1'b0, 1'b0); drain(1'b1);
    rand_block(); send_block(blk, 1'b0, 1'b0); drain(1'b1);

    or_mode = 0;
    send_block(abc, 1'b1, 1'b0);
    budget = 0;
    while (!(out_valid && round == 6'd30) && budget < 500) begin
      @(posedge clk); #1; budget++;
    end
    chk("reach_round30", 64'(round), 64'd30);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_w_out", 64'(w_out), 64'd0);
    chk("midrst_round", 64'(round), 64'd0);
    q.delete();
    @(posedge clk); #1 rst = 1'b0;
    send_block(abc, 1'b1, 1'b0); drain(1'b0);

    or_mode = 1;
    for (int k = 0; k < 3; k++) begin
      rand_block(); send_block(blk, 1'b0, 1'b1); drain(1'b1);
    end

    repeat (4) @(posedge clk);
    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
